// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t        : loader sequencing states
//   HDR_BYTES      : header length (word count + start PC)
//   BYTES_PER_WORD : bytes packed into one instruction word
package boot_pkg;

   localparam int HDR_BYTES      = 8;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      HDR_LEN,
      HDR_PC,
      PAYLOAD,
      RELEASE,
      RUN,
      ERROR
   } state_t;

endpackage

// File: rtl/le_word_packer.sv
// Little-endian byte-to-word packer, shared by header fields and payload.
//   CLK, resetl : clock, async active-low reset
//   accept      : a byte is being taken this cycle
//   byte_val    : the byte being taken
//   clear       : restart at byte 0 (used once loading is over)
//   word        : assembled word, valid when word_done is high
//   word_done   : this accept completes a 4-byte group
module le_word_packer
   import boot_pkg::*;
(
   input  logic        CLK,
   input  logic        resetl,
   input  logic        accept,
   input  logic [7:0]  byte_val,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_done
);

   logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx;
   logic [23:0]                       asm_q;

   // The 4th byte is not stored; it is merged combinationally so the
   // complete word is available on the same edge that accepts it.
   assign word_done = accept && (byte_idx == 2'd3);
   assign word      = {byte_val, asm_q};

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         byte_idx <= '0;
         asm_q    <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (accept) begin
         byte_idx <= byte_idx + 2'd1;
         case (byte_idx)
            2'd0:    asm_q[7:0]   <= byte_val;
            2'd1:    asm_q[15:8]  <= byte_val;
            2'd2:    asm_q[23:16] <= byte_val;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses an 8-byte header (word count N, start PC) from a
// valid/ready byte stream, writes N little-endian words into instruction
// memory, then releases the core at startpc.
//   CLK, resetl          : clock, async active-low reset
//   in_valid/in_byte     : byte stream in; in_ready accepts it
//   imem_we/addr/wdata   : one-cycle instruction-memory write
//   core_resetl, startpc : core run control
//   busy                 : loading in progress (incl. release cycle)
//   err                  : sticky bad-header flag
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int IMEM_DEPTH = 256
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        imem_we,
   output logic [63:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_resetl,
   output logic [63:0] startpc,
   output logic        busy,
   output logic        err
);

   // One extra bit so word_idx can reach IMEM_DEPTH after the last write.
   localparam int IW = $clog2(IMEM_DEPTH) + 1;

   state_t          state, state_nxt;
   logic            armed;       // low only until the first edge after reset
   logic [31:0]     n_q;
   logic [IW-1:0]   word_idx;
   logic            accept, clear, word_done, last_word;
   logic [31:0]     word;

   assign accept    = in_valid & in_ready;
   assign last_word = (32'(word_idx) + 32'd1) == n_q;

   assign in_ready    = armed && (state == HDR_LEN || state == HDR_PC || state == PAYLOAD);
   assign busy        = armed && (state == HDR_LEN || state == HDR_PC ||
                                  state == PAYLOAD || state == RELEASE);
   assign core_resetl = (state == RUN);
   assign err         = (state == ERROR);

   le_word_packer u_packer (
      .CLK       (CLK),
      .resetl    (resetl),
      .accept    (accept),
      .byte_val  (in_byte),
      .clear     (clear),
      .word      (word),
      .word_done (word_done)
   );

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) state <= HDR_LEN;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      case (state)
         HDR_LEN:
            if (word_done)
               state_nxt = (word == '0 || word > 32'(IMEM_DEPTH)) ? ERROR : HDR_PC;
         HDR_PC:
            if (word_done)
               state_nxt = (word[1:0] != 2'b00) ? ERROR : PAYLOAD;
         PAYLOAD:
            if (word_done && last_word) state_nxt = RELEASE;
         RELEASE: begin
            clear     = 1'b1;
            state_nxt = RUN;
         end
         RUN:     clear = 1'b1;
         ERROR:   clear = 1'b1;
         default: state_nxt = HDR_LEN;
      endcase
   end

   // Datapath: header latches and the registered memory write.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         armed      <= 1'b0;
         n_q        <= '0;
         word_idx   <= '0;
         startpc    <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         armed   <= 1'b1;
         imem_we <= 1'b0;
         if (state == HDR_LEN && word_done)
            n_q <= word;
         if (state == HDR_PC && word_done && word[1:0] == 2'b00)
            startpc <= {32'b0, word};
         if (state == PAYLOAD && word_done) begin
            imem_we    <= 1'b1;
            imem_wdata <= word;
            imem_addr  <= 64'({word_idx, 2'b00});
            word_idx   <= word_idx + 1'b1;
         end
      end
   end

endmodule
